// File: rtl/matraptor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matraptor_pkg
// Description : Shared types and helpers for the matraptor merge datapath.
//               Holds the row dispatcher state encoding and a constant
//               ceil(log2()) helper used to size index and counter fields.
// Revision    : 1.0 - initial release with dispatch_state_t
// ============================================================================
package matraptor_pkg;

    // Row dispatcher states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARB    = 2'd1,
        S_STREAM = 2'd2
    } dispatch_state_t;

    // Bits needed to hold values 0..value-1, with a floor of one bit so a
    // degenerate size still yields a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : matraptor_pkg
`default_nettype wire

// File: rtl/row_dispatch_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request found when searching from last+1 upward, wrapping
//               modulo N.
// Ports       : req     [N]        - request vector
//               last    [clog2(N)] - previously granted index
//               gnt_idx [clog2(N)] - granted index (0 when nothing granted)
//               gnt_any            - at least one request was asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import matraptor_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   last,
    output logic [clog2(N)-1:0]   gnt_idx,
    output logic                  gnt_any
);

    localparam int c_w = clog2(N);

    int w_cand;

    // Visit last+1, last+2, ... last+N (mod N); the first hit wins, so the
    // previously granted index is always the lowest priority.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        w_cand  = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(last) + k) % N;
            if (!gnt_any && (((req >> w_cand) & N'(1)) != '0)) begin
                gnt_any = 1'b1;
                gnt_idx = c_w'(w_cand);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/row_dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module      : row_dispatch_sched
// Description : Row-granular scheduler in front of the merge PE array. Each
//               row of the flat partial-product stream is assigned to one PE
//               chosen round-robin among PEs with free row credits; the row's
//               beats are then forwarded to that PE. Credits come back on the
//               per-PE pe_row_done pulse.
// Ports       : in_valid/in_ready/in_val/in_row/in_col/in_last - upstream beat
//               pe_valid[NUM_PES]/pe_ready[NUM_PES]              - per-PE handshake
//               out_val/out_row/out_col/out_last                 - shared data bus
//               pe_row_done[NUM_PES]                             - credit return
//               busy, rows_dispatched, proto_err                 - status
// Revision    : 1.0 - initial release
// ============================================================================
module row_dispatch_sched
    import matraptor_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 16,
    parameter int NUM_PES = 4,
    parameter int MAX_OUT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_val,
    input  logic [IDX_W-1:0]   in_row,
    input  logic [IDX_W-1:0]   in_col,
    input  logic               in_last,
    output logic [NUM_PES-1:0] pe_valid,
    input  logic [NUM_PES-1:0] pe_ready,
    output logic [DATA_W-1:0]  out_val,
    output logic [IDX_W-1:0]   out_row,
    output logic [IDX_W-1:0]   out_col,
    output logic               out_last,
    input  logic [NUM_PES-1:0] pe_row_done,
    output logic               busy,
    output logic [31:0]        rows_dispatched,
    output logic               proto_err
);

    localparam int c_sel_w = clog2(NUM_PES);
    localparam int c_cnt_w = clog2(MAX_OUT + 1);
    localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUT);

    dispatch_state_t                         r_state;
    logic [c_sel_w-1:0]                      r_sel_pe;
    logic [c_sel_w-1:0]                      r_last_pe;
    logic [IDX_W-1:0]                        r_cur_row;
    logic [NUM_PES-1:0][c_cnt_w-1:0]         r_outstanding;
    logic [31:0]                             r_rows_dispatched;
    logic                                    r_proto_err;

    logic [NUM_PES-1:0]                      w_elig;
    logic [NUM_PES-1:0]                      w_bad_done;
    logic [NUM_PES-1:0][c_cnt_w-1:0]         w_out_next;
    logic [c_sel_w-1:0]                      w_gnt_idx;
    logic                                    w_gnt_any;
    logic                                    w_grant;
    logic                                    w_row_change;
    logic                                    w_stream_ok;
    logic [NUM_PES-1:0]                      w_sel_onehot;
    logic                                    w_sel_ready;

    rr_pick #(
        .N (NUM_PES)
    ) u_rr_pick (
        .req     (w_elig),
        .last    (r_last_pe),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    // A grant needs a beat waiting and at least one PE with a free credit.
    assign w_grant = (r_state == S_ARB) && in_valid && w_gnt_any;

    // A beat of a different row arriving before in_last closes the current
    // row; it is held back and re-arbitrated as a new row.
    assign w_row_change = (r_state == S_STREAM) && in_valid && (in_row != r_cur_row);
    assign w_stream_ok  = (r_state == S_STREAM) && !w_row_change;

    // Only registered state selects the PE, so pe_ready never reaches pe_valid.
    assign w_sel_onehot = NUM_PES'(1) << r_sel_pe;
    assign w_sel_ready  = |(pe_ready & w_sel_onehot);

    assign pe_valid = (w_stream_ok && in_valid) ? w_sel_onehot : '0;
    assign in_ready = w_stream_ok && w_sel_ready;

    assign out_val  = in_val;
    assign out_row  = in_row;
    assign out_col  = in_col;
    assign out_last = in_last;

    assign busy            = (r_state != S_IDLE) || (|r_outstanding);
    assign rows_dispatched = r_rows_dispatched;
    assign proto_err       = r_proto_err;

    // Per-PE credit bookkeeping. A grant and a done in the same cycle cancel;
    // a done against an empty counter is dropped and flagged.
    for (genvar g = 0; g < NUM_PES; g++) begin : g_credit
        logic w_inc;
        logic w_dec;
        logic w_empty;

        assign w_inc         = w_grant && (w_gnt_idx == c_sel_w'(g));
        assign w_dec         = pe_row_done[g];
        assign w_empty       = (r_outstanding[g] == '0);
        assign w_elig[g]     = (r_outstanding[g] < c_max_out);
        assign w_bad_done[g] = w_dec && !w_inc && w_empty;

        always_comb begin
            w_out_next[g] = r_outstanding[g];
            if (w_inc && !w_dec) begin
                w_out_next[g] = r_outstanding[g] + c_cnt_w'(1);
            end else if (w_dec && !w_inc && !w_empty) begin
                w_out_next[g] = r_outstanding[g] - c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_sel_pe          <= '0;
            r_last_pe         <= c_sel_w'(NUM_PES - 1);
            r_cur_row         <= '0;
            r_rows_dispatched <= '0;
            r_proto_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_grant) begin
                        r_sel_pe          <= w_gnt_idx;
                        r_last_pe         <= w_gnt_idx;
                        r_cur_row         <= in_row;
                        r_rows_dispatched <= r_rows_dispatched + 32'd1;
                        r_state           <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_row_change) begin
                        r_state <= S_ARB;
                    end else if (in_valid && in_ready && in_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_row_change || (|w_bad_done)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule : row_dispatch_sched
`default_nettype wire
